// File: rtl/mem_access.sv
// Memory stage of the in-order RV64 pipeline: issues loads/stores on the data bus,
// passes other instructions straight through, and presents a registered mem->wb bundle.
module mem_access #(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_inst,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic              dreq_write,
    output logic [XLEN-1:0]   dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [STRB_W-1:0] dreq_strobe,
    output logic [XLEN-1:0]   dreq_data,
    input  logic              dresp_valid,
    input  logic [XLEN-1:0]   dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic [XLEN-1:0]   out_wdata,
    output logic [XLEN-1:0]   out_pc,
    output logic [31:0]       out_inst,
    output logic              out_misalign
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_OUT} state_t;

    state_t state;
    state_t state_nxt;
    state_t dispatch_state;

    // Bundle captured on acceptance; held for the whole bus transaction.
    logic              is_load_p0;
    logic [2:0]        funct3_p0;
    logic [XLEN-1:0]   addr_p0;
    logic [XLEN-1:0]   store_data_p0;
    logic [4:0]        rd_p0;
    logic              rd_we_p0;
    logic [XLEN-1:0]   pc_p0;
    logic [31:0]       inst_p0;

    logic in_is_load;
    logic in_is_mem;
    logic in_misalign;
    logic in_bypass;
    logic accept;

    function automatic logic [2:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [STRB_W-1:0] store_strobe(input logic [1:0] size,
                                                       input logic [2:0] off);
        logic [STRB_W-1:0] m;
        case (size)
            2'd0:    m = STRB_W'(8'h01);
            2'd1:    m = STRB_W'(8'h03);
            2'd2:    m = STRB_W'(8'h0F);
            default: m = STRB_W'(8'hFF);
        endcase
        return m << off;
    endfunction

    // Bring the addressed lane down to bit 0, then sign- or zero-extend by size.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                    input logic [2:0]      off,
                                                    input logic [2:0]      f3);
        logic [XLEN-1:0] sh;
        logic            sx;
        sh = raw >> {off, 3'b000};
        case (f3[1:0])
            2'd0: begin
                sx = sh[7] & ~f3[2];
                return {{(XLEN-8){sx}}, sh[7:0]};
            end
            2'd1: begin
                sx = sh[15] & ~f3[2];
                return {{(XLEN-16){sx}}, sh[15:0]};
            end
            2'd2: begin
                sx = sh[31] & ~f3[2];
                return {{(XLEN-32){sx}}, sh[31:0]};
            end
            default: return sh;
        endcase
    endfunction

    assign in_is_load     = (in_opcode == OP_LOAD);
    assign in_is_mem      = in_is_load || (in_opcode == OP_STORE);
    assign in_misalign    = in_is_mem &&
                            ((in_alu_result[2:0] & size_mask(in_funct3[1:0])) != 3'b000);
    assign in_bypass      = !in_is_mem || in_misalign;
    assign accept         = in_valid && in_ready;
    assign dispatch_state = in_bypass ? S_OUT : S_REQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)      state_nxt = dispatch_state;
            S_REQ:   if (dreq_ready)  state_nxt = S_RESP;
            S_RESP:  if (dresp_valid) state_nxt = S_OUT;
            S_OUT:   if (out_ready)   state_nxt = accept ? dispatch_state : S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        dreq_valid  = 1'b0;
        dreq_write  = 1'b0;
        dreq_addr   = '0;
        dreq_size   = 3'd0;
        dreq_strobe = '0;
        dreq_data   = '0;
        case (state)
            S_IDLE, S_OUT: in_ready = !out_valid || out_ready;
            S_REQ: begin
                dreq_valid = 1'b1;
                dreq_write = !is_load_p0;
                dreq_addr  = addr_p0;
                dreq_size  = {1'b0, funct3_p0[1:0]};
                if (!is_load_p0) begin
                    dreq_strobe = store_strobe(funct3_p0[1:0], addr_p0[2:0]);
                    dreq_data   = store_data_p0 << {addr_p0[2:0], 3'b000};
                end
            end
            default: ;
        endcase
    end

    // p0: capture the accepted ex->mem bundle
    always_ff @(posedge clk) begin
        if (accept) begin
            is_load_p0    <= in_is_load;
            funct3_p0     <= in_funct3;
            addr_p0       <= in_alu_result;
            store_data_p0 <= in_store_data;
            rd_p0         <= in_rd;
            rd_we_p0      <= in_rd_we;
            pc_p0         <= in_pc;
            inst_p0       <= in_inst;
        end
    end

    // p1: registered mem->wb bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_rd       <= 5'd0;
            out_rd_we    <= 1'b0;
            out_wdata    <= '0;
            out_pc       <= '0;
            out_inst     <= 32'd0;
            out_misalign <= 1'b0;
        end else if (accept && in_bypass) begin
            out_valid    <= 1'b1;
            out_rd       <= in_rd;
            out_rd_we    <= in_rd_we && !in_misalign;
            out_wdata    <= in_misalign ? '0 : in_alu_result;
            out_pc       <= in_pc;
            out_inst     <= in_inst;
            out_misalign <= in_misalign;
        end else if (accept) begin
            out_valid    <= 1'b0;
        end else if (state == S_RESP && dresp_valid) begin
            out_valid    <= 1'b1;
            out_rd       <= rd_p0;
            out_rd_we    <= is_load_p0 && rd_we_p0;
            out_wdata    <= is_load_p0 ? load_extend(dresp_data, addr_p0[2:0], funct3_p0) : '0;
            out_pc       <= pc_p0;
            out_inst     <= inst_p0;
            out_misalign <= 1'b0;
        end else if (state == S_OUT && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scoreboard of expected mem->wb bundles plus
// direct checks of the bus request side, reset behaviour and backpressure.
module tb_mem_access;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [63:0] in_alu_result;
    logic [63:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        dreq_valid;
    logic        dreq_ready;
    logic        dreq_write;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_valid;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [63:0] out_wdata;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;

    always #5 clk = ~clk;

    mem_access #(.XLEN(64), .STRB_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_pc(in_pc), .in_inst(in_inst),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_write(dreq_write),
        .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_wdata(out_wdata), .out_pc(out_pc),
        .out_inst(out_inst), .out_misalign(out_misalign)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        rd_we;
        logic [63:0] wdata;
        logic        chk_wdata;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [4:0] rd,
                                            input logic [63:0] pc);
        return {pc[19:0], rd, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] alu,
                         input logic [63:0] sd, input logic [4:0] rd, input logic we,
                         input logic [63:0] pc);
        in_valid      = 1'b1;
        in_opcode     = op;
        in_funct3     = f3;
        in_alu_result = alu;
        in_store_data = sd;
        in_rd         = rd;
        in_rd_we      = we;
        in_pc         = pc;
        in_inst       = mk_inst(op, rd, pc);
    endtask

    task automatic push(input logic [4:0] rd, input logic we, input logic [63:0] wdata,
                        input logic chk, input logic [63:0] pc, input logic [31:0] inst,
                        input logic mis);
        exp_t e;
        e.rd = rd; e.rd_we = we; e.wdata = wdata; e.chk_wdata = chk;
        e.pc = pc; e.inst = inst; e.misalign = mis;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if ({dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data, out_valid,
             out_rd, out_rd_we, out_wdata, out_pc, out_inst, out_misalign} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got dreq_valid=%b out_valid=%b wdata=%h want all 0",
                     dreq_valid, out_valid, out_wdata);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi_b2b();
        logic [63:0] alus [3];
        logic [63:0] pc;
        exp_t e;
        alus[0] = 64'h1234; alus[1] = 64'h5678; alus[2] = 64'h9ABC;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL addi_in_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                pc = 64'h100 + 64'(4 * i);
                drive(OP_IMM, 3'b000, alus[i], 64'h0, 5'(5 + i), 1'b1, pc);
                push(5'(5 + i), 1'b1, alus[i], 1'b1, pc, mk_inst(OP_IMM, 5'(5 + i), pc), 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || out_rd !== e.rd || out_rd_we !== e.rd_we ||
                    (e.chk_wdata && out_wdata !== e.wdata) || out_pc !== e.pc ||
                    out_inst !== e.inst || out_misalign !== e.misalign) begin
                    errors++;
                    $display("FAIL addi_b2b[%0d]: got v=%b rd=%0d we=%b wd=%h pc=%h mis=%b want v=1 rd=%0d we=%b wd=%h pc=%h mis=%b",
                             i - 1, out_valid, out_rd, out_rd_we, out_wdata, out_pc, out_misalign,
                             e.rd, e.rd_we, e.wdata, e.pc, e.misalign);
                end
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_mem_access_op(input string name, input logic [6:0] op,
                                      input logic [2:0] f3, input logic [63:0] addr,
                                      input logic [63:0] sd, input logic [63:0] resp,
                                      input logic [7:0] exp_strobe, input logic [63:0] exp_data,
                                      input logic [63:0] exp_wdata, input logic [4:0] rd);
        logic        is_store;
        logic [63:0] pc;
        exp_t        e;
        is_store   = (op == OP_STORE);
        pc         = addr ^ 64'h8000_0000;
        out_ready  = 1'b1;
        dreq_ready = 1'b1;
        drive(op, f3, addr, sd, rd, 1'b1, pc);
        push(rd, !is_store, exp_wdata, 1'b1, pc, mk_inst(op, rd, pc), 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if (dreq_valid !== 1'b1 || dreq_write !== is_store || dreq_addr !== addr ||
            dreq_size !== {1'b0, f3[1:0]} || dreq_strobe !== exp_strobe ||
            (is_store && dreq_data !== exp_data) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_req: got v=%b w=%b a=%h sz=%0d st=%h d=%h rdy=%b want v=1 w=%b a=%h sz=%0d st=%h d=%h rdy=0",
                     name, dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data,
                     in_ready, is_store, addr, f3[1:0], exp_strobe, exp_data);
        end
        step();
        dresp_valid = 1'b1;
        dresp_data  = resp;
        checks++;
        if (dreq_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_resp_wait: got dreq_valid=%b out_valid=%b in_ready=%b want 0 0 0",
                     name, dreq_valid, out_valid, in_ready);
        end
        step();
        dresp_valid = 1'b0;
        dresp_data  = 64'h0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rd !== e.rd || out_rd_we !== e.rd_we ||
            (e.chk_wdata && out_wdata !== e.wdata) || out_pc !== e.pc ||
            out_inst !== e.inst || out_misalign !== e.misalign) begin
            errors++;
            $display("FAIL %s_out: got v=%b rd=%0d we=%b wd=%h pc=%h mis=%b want v=1 rd=%0d we=%b wd=%h pc=%h mis=%b",
                     name, out_valid, out_rd, out_rd_we, out_wdata, out_pc, out_misalign,
                     e.rd, e.rd_we, e.wdata, e.pc, e.misalign);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: out_valid got %b want 0", name, out_valid);
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] pc;
        exp_t        e;
        pc        = 64'h300;
        out_ready = 1'b1;
        drive(OP_LOAD, 3'b010, 64'h1002, 64'h0, 5'd8, 1'b1, pc);
        push(5'd8, 1'b0, 64'h0, 1'b0, pc, mk_inst(OP_LOAD, 5'd8, pc), 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (dreq_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_no_req: dreq_valid got %b want 0", dreq_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rd !== e.rd || out_rd_we !== e.rd_we ||
            (e.chk_wdata && out_wdata !== e.wdata) || out_pc !== e.pc ||
            out_inst !== e.inst || out_misalign !== e.misalign) begin
            errors++;
            $display("FAIL misalign_out: got v=%b rd=%0d we=%b pc=%h mis=%b want v=1 rd=%0d we=%b pc=%h mis=%b",
                     out_valid, out_rd, out_rd_we, out_pc, out_misalign,
                     e.rd, e.rd_we, e.pc, e.misalign);
        end
        step();
        checks++;
        if (dreq_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after: dreq_valid=%b out_valid=%b want 0 0", dreq_valid, out_valid);
        end
    endtask

    task automatic test_dreq_backpressure();
        exp_t e;
        out_ready  = 1'b1;
        dreq_ready = 1'b0;
        drive(OP_LOAD, 3'b011, 64'h3000, 64'h0, 5'd9, 1'b1, 64'h400);
        push(5'd9, 1'b1, 64'h1122334455667788, 1'b1, 64'h400, mk_inst(OP_LOAD, 5'd9, 64'h400), 1'b0);
        step();
        drive(OP_IMM, 3'b000, 64'h77, 64'h0, 5'd10, 1'b1, 64'h404);
        push(5'd10, 1'b1, 64'h77, 1'b1, 64'h404, mk_inst(OP_IMM, 5'd10, 64'h404), 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) dreq_ready = 1'b1;
            checks++;
            if (dreq_valid !== 1'b1 || dreq_addr !== 64'h3000 || dreq_size !== 3'd3 ||
                dreq_write !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL dreq_stall[%0d]: got v=%b a=%h sz=%0d w=%b in_ready=%b want v=1 a=3000 sz=3 w=0 in_ready=0",
                         i, dreq_valid, dreq_addr, dreq_size, dreq_write, in_ready);
            end
            step();
        end
        dresp_valid = 1'b1;
        dresp_data  = 64'h1122334455667788;
        step();
        dresp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_rd !== e.rd || out_rd_we !== e.rd_we ||
                (e.chk_wdata && out_wdata !== e.wdata) || out_pc !== e.pc ||
                out_inst !== e.inst || out_misalign !== e.misalign) begin
                errors++;
                $display("FAIL dreq_bp_out[%0d]: got v=%b rd=%0d we=%b wd=%h pc=%h want v=1 rd=%0d we=%b wd=%h pc=%h",
                         i, out_valid, out_rd, out_rd_we, out_wdata, out_pc,
                         e.rd, e.rd_we, e.wdata, e.pc);
            end
            step();
            in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dreq_bp_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_out_backpressure();
        exp_t e;
        out_ready = 1'b0;
        drive(OP_IMM, 3'b000, 64'hAAAA, 64'h0, 5'd11, 1'b1, 64'h500);
        push(5'd11, 1'b1, 64'hAAAA, 1'b1, 64'h500, mk_inst(OP_IMM, 5'd11, 64'h500), 1'b0);
        step();
        drive(OP_IMM, 3'b000, 64'hBBBB, 64'h0, 5'd12, 1'b1, 64'h504);
        push(5'd12, 1'b1, 64'hBBBB, 1'b1, 64'h504, mk_inst(OP_IMM, 5'd12, 64'h504), 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_rd !== 5'd11 || out_wdata !== 64'hAAAA ||
                out_pc !== 64'h500 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL out_hold[%0d]: got v=%b rd=%0d wd=%h pc=%h in_ready=%b want v=1 rd=11 wd=aaaa pc=500 in_ready=0",
                         i, out_valid, out_rd, out_wdata, out_pc, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_rd !== e.rd || out_rd_we !== e.rd_we ||
                (e.chk_wdata && out_wdata !== e.wdata) || out_pc !== e.pc ||
                out_inst !== e.inst || out_misalign !== e.misalign) begin
                errors++;
                $display("FAIL out_bp_out[%0d]: got v=%b rd=%0d we=%b wd=%h pc=%h want v=1 rd=%0d we=%b wd=%h pc=%h",
                         i, out_valid, out_rd, out_rd_we, out_wdata, out_pc,
                         e.rd, e.rd_we, e.wdata, e.pc);
            end
            step();
            in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_bp_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_in_resp();
        out_ready  = 1'b1;
        dreq_ready = 1'b1;
        drive(OP_LOAD, 3'b011, 64'h4000, 64'h0, 5'd14, 1'b1, 64'h600);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b0 || dreq_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp_state: in_ready=%b dreq_valid=%b out_valid=%b want 0 0 0",
                     in_ready, dreq_valid, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || {dreq_valid, dreq_addr, dreq_strobe, out_valid, out_rd,
                                  out_rd_we, out_wdata, out_pc, out_inst, out_misalign} !== '0) begin
            errors++;
            $display("FAIL rst_resp_outputs: in_ready=%b dreq_valid=%b out_valid=%b out_pc=%h want 1 0 0 0",
                     in_ready, dreq_valid, out_valid, out_pc);
        end
        step();
        rst_n       = 1'b1;
        dresp_valid = 1'b1;
        dresp_data  = 64'hFFFF_0000_FFFF_0000;
        step();
        dresp_valid = 1'b0;
        dresp_data  = 64'h0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || dreq_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_late_resp[%0d]: out_valid=%b in_ready=%b dreq_valid=%b want 0 1 0",
                         i, out_valid, in_ready, dreq_valid);
            end
            step();
        end
        test_mem_access_op("ld_after_reset", OP_LOAD, 3'b011, 64'h4008, 64'h0,
                           64'hDEADBEEF_CAFEF00D, 8'h00, 64'h0, 64'hDEADBEEF_CAFEF00D, 5'd13);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 7'd0; in_funct3 = 3'd0;
        in_alu_result = 64'h0; in_store_data = 64'h0; in_rd = 5'd0; in_rd_we = 1'b0;
        in_pc = 64'h0; in_inst = 32'h0; dreq_ready = 1'b1; dresp_valid = 1'b0;
        dresp_data = 64'h0; out_ready = 1'b1;

        test_reset();
        test_addi_b2b();
        test_mem_access_op("lb", OP_LOAD, 3'b000, 64'h1003, 64'h0, 64'h00000000_80000000,
                           8'h00, 64'h0, 64'hFFFFFFFF_FFFFFF80, 5'd1);
        test_mem_access_op("lbu", OP_LOAD, 3'b100, 64'h1003, 64'h0, 64'h00000000_80000000,
                           8'h00, 64'h0, 64'h00000000_00000080, 5'd2);
        test_mem_access_op("lw", OP_LOAD, 3'b010, 64'h1004, 64'h0, 64'h80000001_00000000,
                           8'h00, 64'h0, 64'hFFFFFFFF_80000001, 5'd3);
        test_mem_access_op("sh", OP_STORE, 3'b001, 64'h2006, 64'hABCD, 64'h0,
                           8'hC0, 64'hABCD0000_00000000, 64'h0, 5'd4);
        test_mem_access_op("sw", OP_STORE, 3'b010, 64'h2004, 64'h11223344, 64'h0,
                           8'hF0, 64'h11223344_00000000, 64'h0, 5'd6);
        test_misaligned();
        test_dreq_backpressure();
        test_out_backpressure();
        test_reset_in_resp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
